ex_issue_stage: RTL and testbench
=================================

Name: ex_issue_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage of the riscv32i core.
- Sits directly upstream of the ALU.
- Captures decoded instructions, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards.
- Presents ALU operands a/b, alucont and sltunsigned, with a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, datapath width.
- RBITS, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  synchronous active-low reset.
- id_valid  in  1  decode has an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_rs1, id_rs2  in  RBITS  source indices.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_alusrc  in  1  1 selects id_imm as operand b.
- id_alucont  in  4  ALU control.
- id_sltunsigned  in  1  unsigned compare.
- id_rd  in  RBITS  destination.
- id_regwrite  in  1  writes rd.
- id_memread  in  1  instruction is a load.
- flush  in  1  kill the held instruction (branch redirect).
- exm_rd, exm_regwrite, exm_result  in  RBITS/1/XLEN  EX/MEM forwarding source.
- exm_memread  in  1  EX/MEM holds a load; its result is not yet valid.
- wb_rd, wb_regwrite, wb_result  in  RBITS/1/XLEN  MEM/WB forwarding source.
- ex_valid  out  1  operands valid.
- ex_ready  in  1  downstream consumes.
- a, b  out  XLEN  ALU operands.
- alucont  out  4  registered id_alucont.
- sltunsigned  out  1  registered id_sltunsigned.
- store_data  out  XLEN  forwarded rs2 (for stores).
- ex_rd, ex_regwrite, ex_memread  out  RBITS/1/1  registered control.

Behaviour:
- Reset (resetn=0 at posedge): ex_valid=0 and every registered field = 0, so a=b=store_data=0, alucont=0, ex_rd=0. id_ready tracks its equation (1 with no hazard).
- Occupancy:
  - full = ex_valid.
  - advance = !ex_valid | ex_ready.
  - load_use = ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | (!id_alusrc & ex_rd==id_rs2)).
  - id_ready = advance & !load_use.
- Posedge priority, highest first:
  1. reset.
  2. flush: ex_valid<=0, control fields cleared.
  3. id_valid & id_ready: capture all id_* fields, ex_valid<=1.
  4. advance & !(id_valid & id_ready): ex_valid<=0 (bubble). Load-use inserts exactly one bubble.
  5. hold, i.e. ex_valid & !ex_ready: fields kept, but stored rs1/rs2 data are overwritten with the forwarded values, so a WB value that retires during the stall is not lost.
- Forwarding, combinational on the stored rs indices:
  - Rs1: if rs!=0 & exm_regwrite & !exm_memread & exm_rd==rs, use exm_result. Otherwise if rs!=0 & wb_regwrite & wb_rd==rs, use wb_result. Otherwise use the stored data.
  - Rs2 uses the same rule.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Operands:
  - a = fwd_rs1.
  - b = alusrc ? imm : fwd_rs2.
  - store_data = fwd_rs2.
- Latency: 1 cycle from id handshake to ex_valid.
- Simultaneous events:
  - flush with id_valid: the instruction is dropped, id_ready is unaffected by flush, and decode must also squash it.
  - flush while holding: the held instruction is discarded.
  - Reset mid-stall: stage empties.

Optional Feature:
- Macro EXSTAGE_FWD_EN.
- Defined: forwarding as above.
- Undefined:
  - No forwarding paths; a/b/store_data come from stored data only.
  - id_ready additionally deasserts while id_rs1 or id_rs2 (rs2 only if !id_alusrc), when nonzero, matches a writing destination in EX (ex_rd), EX/MEM (exm_rd) or MEM/WB (wb_rd).
  - The load_use term is subsumed by this rule.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and RBITS constants.
  - ALU control encodings: AND=4'b0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, XOR=1000.
  - A struct for the ID/EX payload.
- One sub-module, fwd_mux: a single-operand forward select instantiated twice.

Test Plan:
- Reset: hold resetn=0 two cycles with id_valid=1 -> ex_valid=0, a=b=0; first accept on the cycle after release.
- EX/MEM forward priority: exm_rd=5, exm_result=0x11; wb_rd=5, wb_result=0x22; stored rs1=5 data 0x99 -> a=0x11. Drop exm_regwrite -> a=0x22.
- Load-use: EX holds lw x7, next instruction add x8,x7,x1 -> id_ready=0 one cycle, one bubble, then accepted. Same case with rs1=x0 target -> no stall.
- Stall refresh: ex_ready=0 for 3 cycles, wb forwards x3=0xDEAD in cycle 1 only -> a stays 0xDEAD through cycle 3.
- Flush concurrent with id_valid & id_ready -> ex_valid=0 next cycle.
- alusrc=1, imm=0xFFFFFFFC, rs2 forwarded 0x5 -> b=0xFFFFFFFC, store_data=0x5.
- With EXSTAGE_FWD_EN undefined: RAW on wb_rd=4 -> id_ready=0 until the writeback clears.

Source files
------------

// File: rtl/riscv_pkg.sv
// ============================================================================
// Module : riscv_pkg
// Shared riscv32i constants, ALU control encodings and the ID/EX payload.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int RBITS = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_XOR = 4'b1000;

    typedef struct packed {
        logic [RBITS-1:0] rs1;
        logic [RBITS-1:0] rs2;
        logic [XLEN-1:0]  rs1_data;
        logic [XLEN-1:0]  rs2_data;
        logic [XLEN-1:0]  imm;
        logic             alusrc;
        logic [3:0]       alucont;
        logic             sltunsigned;
        logic [RBITS-1:0] rd;
        logic             regwrite;
        logic             memread;
    } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/ex_issue_stage_fwd_mux.sv
// ============================================================================
// Module : fwd_mux
// Single-operand forward select; bypass paths exist only with EXSTAGE_FWD_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fwd_mux #(
    parameter int XLEN  = 32,
    parameter int RBITS = 5
) (
    input  logic [RBITS-1:0] rs,
    input  logic [XLEN-1:0]  stored_data,
    input  logic [RBITS-1:0] exm_rd,
    input  logic             exm_regwrite,
    input  logic             exm_memread,
    input  logic [XLEN-1:0]  exm_result,
    input  logic [RBITS-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic [XLEN-1:0]  wb_result,
    output logic [XLEN-1:0]  fwd_data
);

`ifdef EXSTAGE_FWD_EN
    // A load in EX/MEM has no result yet, so it can never be a bypass source.
    always_comb begin
        fwd_data = stored_data;
        if (rs != '0 && exm_regwrite && !exm_memread && exm_rd == rs)
            fwd_data = exm_result;
        else if (rs != '0 && wb_regwrite && wb_rd == rs)
            fwd_data = wb_result;
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{rs, exm_rd, exm_regwrite, exm_memread, exm_result,
                                 wb_rd, wb_regwrite, wb_result};
    assign fwd_data = stored_data;
`endif

endmodule

`default_nettype wire

// File: rtl/ex_issue_stage.sv
// ============================================================================
// Module : ex_issue_stage
// ID/EX register with RAW forwarding (EXSTAGE_FWD_EN) or interlock, plus load-use stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ex_issue_stage #(
    parameter int XLEN  = 32,
    parameter int RBITS = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [RBITS-1:0] id_rs1,
    input  logic [RBITS-1:0] id_rs2,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic             id_alusrc,
    input  logic [3:0]       id_alucont,
    input  logic             id_sltunsigned,
    input  logic [RBITS-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             flush,
    input  logic [RBITS-1:0] exm_rd,
    input  logic             exm_regwrite,
    input  logic [XLEN-1:0]  exm_result,
    input  logic             exm_memread,
    input  logic [RBITS-1:0] wb_rd,
    input  logic             wb_regwrite,
    input  logic [XLEN-1:0]  wb_result,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [XLEN-1:0]  a,
    output logic [XLEN-1:0]  b,
    output logic [3:0]       alucont,
    output logic             sltunsigned,
    output logic [XLEN-1:0]  store_data,
    output logic [RBITS-1:0] ex_rd,
    output logic             ex_regwrite,
    output logic             ex_memread
);

    import riscv_pkg::*;

    id_ex_t          r_q;
    logic            r_valid;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_advance;
    logic            w_load_use;
    logic            w_accept;

    assign w_advance  = !r_valid || ex_ready;
    assign w_load_use = r_valid && r_q.memread && (r_q.rd != '0) &&
                        ((r_q.rd == id_rs1) || (!id_alusrc && (r_q.rd == id_rs2)));

`ifdef EXSTAGE_FWD_EN
    assign id_ready = w_advance && !w_load_use;
`else
    function automatic logic raw_hit(input logic [RBITS-1:0] rd, input logic we);
        return we && (rd != '0) && ((rd == id_rs1) || (!id_alusrc && (rd == id_rs2)));
    endfunction

    // Without bypass paths every in-flight writer of a source register interlocks.
    logic w_raw;
    assign w_raw    = raw_hit(r_q.rd, r_valid && r_q.regwrite) ||
                      raw_hit(exm_rd, exm_regwrite) ||
                      raw_hit(wb_rd, wb_regwrite);
    assign id_ready = w_advance && !w_load_use && !w_raw;
`endif

    assign w_accept = id_valid && id_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_q     <= '0;
        end else if (w_accept) begin
            r_valid            <= 1'b1;
            r_q.rs1            <= id_rs1;
            r_q.rs2            <= id_rs2;
            r_q.rs1_data       <= id_rs1_data;
            r_q.rs2_data       <= id_rs2_data;
            r_q.imm            <= id_imm;
            r_q.alusrc         <= id_alusrc;
            r_q.alucont        <= id_alucont;
            r_q.sltunsigned    <= id_sltunsigned;
            r_q.rd             <= id_rd;
            r_q.regwrite       <= id_regwrite;
            r_q.memread        <= id_memread;
        end else if (w_advance) begin
            r_valid <= 1'b0;
        end else begin
            // Stalled: absorb values that retire while we wait so they are not lost.
            r_q.rs1_data <= w_fwd_rs1;
            r_q.rs2_data <= w_fwd_rs2;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_rs1 (
        .rs           (r_q.rs1),
        .stored_data  (r_q.rs1_data),
        .exm_rd       (exm_rd),
        .exm_regwrite (exm_regwrite),
        .exm_memread  (exm_memread),
        .exm_result   (exm_result),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_result    (wb_result),
        .fwd_data     (w_fwd_rs1)
    );

    fwd_mux #(.XLEN(XLEN), .RBITS(RBITS)) u_fwd_rs2 (
        .rs           (r_q.rs2),
        .stored_data  (r_q.rs2_data),
        .exm_rd       (exm_rd),
        .exm_regwrite (exm_regwrite),
        .exm_memread  (exm_memread),
        .exm_result   (exm_result),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .wb_result    (wb_result),
        .fwd_data     (w_fwd_rs2)
    );

    assign ex_valid    = r_valid;
    assign a           = w_fwd_rs1;
    assign b           = r_q.alusrc ? r_q.imm : w_fwd_rs2;
    assign store_data  = w_fwd_rs2;
    assign alucont     = r_q.alucont;
    assign sltunsigned = r_q.sltunsigned;
    assign ex_rd       = r_q.rd;
    assign ex_regwrite = r_q.regwrite;
    assign ex_memread  = r_q.memread;

endmodule

`default_nettype wire

// File: tb/tb_ex_issue_stage.sv
// ============================================================================
// Module : tb_ex_issue_stage
// Self-checking bench for ex_issue_stage in either EXSTAGE_FWD_EN build.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ex_issue_stage;
    import riscv_pkg::*;

`ifdef EXSTAGE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        id_valid, id_ready;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        id_alusrc, id_sltunsigned, id_regwrite, id_memread;
    logic [3:0]  id_alucont;
    logic        flush;
    logic [4:0]  exm_rd, wb_rd;
    logic        exm_regwrite, exm_memread, wb_regwrite;
    logic [31:0] exm_result, wb_result;
    logic        ex_valid, ex_ready;
    logic [31:0] a, b, store_data;
    logic [3:0]  alucont;
    logic        sltunsigned;
    logic [4:0]  ex_rd;
    logic        ex_regwrite, ex_memread;

    int n_cmp = 0;
    int n_bad = 0;

    ex_issue_stage #(.XLEN(32), .RBITS(5)) dut (
        .clk(clk), .resetn(resetn),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_alusrc(id_alusrc), .id_alucont(id_alucont),
        .id_sltunsigned(id_sltunsigned), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush),
        .exm_rd(exm_rd), .exm_regwrite(exm_regwrite), .exm_result(exm_result),
        .exm_memread(exm_memread),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .a(a), .b(b), .alucont(alucont), .sltunsigned(sltunsigned),
        .store_data(store_data),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction currently held in EX, as plain fields.
    bit          m_valid = 1'b0;
    logic [4:0]  m_rs1 = '0, m_rs2 = '0, m_rd = '0;
    logic [31:0] m_d1 = '0, m_d2 = '0, m_imm = '0;
    bit          m_alusrc = 1'b0, m_slt = 1'b0, m_rw = 1'b0, m_mr = 1'b0;
    logic [3:0]  m_ac = '0;

    function automatic logic [31:0] fwd_val(input logic [4:0] idx, input logic [31:0] stored);
        if (FWD && idx != 0 && exm_regwrite && !exm_memread && exm_rd == idx) return exm_result;
        if (FWD && idx != 0 && wb_regwrite && wb_rd == idx) return wb_result;
        return stored;
    endfunction

    function automatic bit reads_reg(input logic [4:0] r);
        return r != 0 && (r == id_rs1 || (!id_alusrc && r == id_rs2));
    endfunction

    function automatic bit exp_ready();
        bit free_slot;
        bit stall;
        free_slot = !m_valid || ex_ready;
        stall = m_valid && m_mr && reads_reg(m_rd);
        if (!FWD)
            stall = stall || (m_valid && m_rw && reads_reg(m_rd)) ||
                    (exm_regwrite && reads_reg(exm_rd)) ||
                    (wb_regwrite && reads_reg(wb_rd));
        return free_slot && !stall;
    endfunction

    always @(posedge clk) begin
        if (!resetn || flush) begin
            m_valid <= 1'b0;
            m_rs1 <= '0; m_rs2 <= '0; m_rd <= '0; m_d1 <= '0; m_d2 <= '0; m_imm <= '0;
            m_alusrc <= 1'b0; m_slt <= 1'b0; m_rw <= 1'b0; m_mr <= 1'b0; m_ac <= '0;
        end else if (id_valid && exp_ready()) begin
            m_valid <= 1'b1;
            m_rs1 <= id_rs1; m_rs2 <= id_rs2; m_rd <= id_rd;
            m_d1 <= id_rs1_data; m_d2 <= id_rs2_data; m_imm <= id_imm;
            m_alusrc <= id_alusrc; m_slt <= id_sltunsigned;
            m_rw <= id_regwrite; m_mr <= id_memread; m_ac <= id_alucont;
        end else if (!m_valid || ex_ready) begin
            m_valid <= 1'b0;
        end else begin
            m_d1 <= fwd_val(m_rs1, m_d1);
            m_d2 <= fwd_val(m_rs2, m_d2);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        chk("id_ready", {31'd0, id_ready}, {31'd0, exp_ready()});
        if (m_valid) begin
            chk("a", a, fwd_val(m_rs1, m_d1));
            chk("b", b, m_alusrc ? m_imm : fwd_val(m_rs2, m_d2));
            chk("store_data", store_data, fwd_val(m_rs2, m_d2));
            chk("alucont", {28'd0, alucont}, {28'd0, m_ac});
            chk("sltunsigned", {31'd0, sltunsigned}, {31'd0, m_slt});
            chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
            chk("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m_rw});
            chk("ex_memread", {31'd0, ex_memread}, {31'd0, m_mr});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input bit asrc, input logic [3:0] ac, input bit slt,
                         input logic [4:0] rd, input bit rw, input bit mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
        id_imm = imm; id_alusrc = asrc; id_alucont = ac; id_sltunsigned = slt;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic srcs(input logic [4:0] erd, input bit erw, input bit emr, input logic [31:0] eres,
                        input logic [4:0] wrd, input bit wrw, input logic [31:0] wres);
        exm_rd = erd; exm_regwrite = erw; exm_memread = emr; exm_result = eres;
        wb_rd = wrd; wb_regwrite = wrw; wb_result = wres;
    endtask

    task automatic idle();
        id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        srcs(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        issue(1, 1, 2, 32'h100, 32'h200, 0, 0, ALU_ADD, 0, 3, 1, 0);

        // Reset held two cycles with a pending instruction
        tick(); tick(); #1;
        chk("rst_ex_valid", {31'd0, ex_valid}, 0);
        chk("rst_a", a, 0);
        chk("rst_b", b, 0);
        chk("rst_store", store_data, 0);
        chk("rst_ex_rd", {27'd0, ex_rd}, 0);

        // First accept right after release
        resetn = 1'b1;
        tick(); #1;
        chk("acc_valid", {31'd0, ex_valid}, 1);
        chk("acc_a", a, 32'h100);
        chk("acc_b", b, 32'h200);
        chk("acc_alucont", {28'd0, alucont}, {28'd0, ALU_ADD});
        chk("acc_ex_rd", {27'd0, ex_rd}, 3);

        // Dependent ALU op: forwarded build accepts, interlocked build waits on EX
        issue(1, 3, 0, 32'h7, 0, 0, 0, ALU_SUB, 0, 4, 1, 0);
        #1 chk("dep_ready", {31'd0, id_ready}, {31'd0, FWD});
        tick();
        chk("dep_valid", {31'd0, ex_valid}, {31'd0, FWD});
        if (!FWD) tick();
        idle(); #1;
        chk("dep_a", a, 32'h7);
        chk("dep_alucont", {28'd0, alucont}, {28'd0, ALU_SUB});
        tick();
        chk("bubble", {31'd0, ex_valid}, 0);

        // EX/MEM over MEM/WB priority, then WB only, then load in EX/MEM is bypassed
        issue(1, 5, 0, 32'h99, 0, 0, 0, ALU_OR, 1, 0, 0, 0);
        tick();
        idle(); ex_ready = 1'b0;
        srcs(5, 1, 0, 32'h11, 5, 1, 32'h22); #1;
        chk("prio_exm", a, FWD ? 32'h11 : 32'h99);
        chk("prio_slt", {31'd0, sltunsigned}, 1);
        tick();
        exm_regwrite = 1'b0; #1;
        chk("prio_wb", a, FWD ? 32'h22 : 32'h99);
        tick();
        srcs(5, 1, 1, 32'h11, 5, 1, 32'h22); #1;
        chk("prio_load", a, FWD ? 32'h22 : 32'h99);
        tick();
        srcs(0, 0, 0, 0, 0, 0, 0); #1;
        chk("prio_kept", a, FWD ? 32'h22 : 32'h99);
        ex_ready = 1'b1;
        tick();

        // Load-use: exactly one bubble
        issue(1, 1, 0, 32'h40, 0, 4, 1, ALU_ADD, 0, 7, 1, 1);
        tick();
        issue(1, 7, 1, 0, 32'h1, 0, 0, ALU_ADD, 0, 8, 1, 0); #1;
        chk("lu_ready", {31'd0, id_ready}, 0);
        tick();
        chk("lu_bubble", {31'd0, ex_valid}, 0);
        chk("lu_ready2", {31'd0, id_ready}, 1);
        tick();
        chk("lu_accept", {31'd0, ex_valid}, 1);
        chk("lu_rd", {27'd0, ex_rd}, 8);
        idle(); tick();
        // Load to x0 never stalls
        issue(1, 1, 0, 32'h40, 0, 4, 1, ALU_ADD, 0, 0, 1, 1);
        tick();
        issue(1, 0, 1, 0, 32'h1, 0, 0, ALU_ADD, 0, 8, 1, 0); #1;
        chk("x0_ready", {31'd0, id_ready}, 1);
        tick(); idle(); tick();

        // Stall refresh: WB value seen only in the first stall cycle is retained
        issue(1, 3, 0, 0, 0, 0, 0, ALU_ADD, 0, 9, 1, 0);
        tick();
        idle(); ex_ready = 1'b0;
        srcs(0, 0, 0, 0, 3, 1, 32'hDEAD); #1;
        chk("stall_c1", a, FWD ? 32'hDEAD : 32'h0);
        tick();
        srcs(0, 0, 0, 0, 0, 0, 0); #1;
        chk("stall_c2", a, FWD ? 32'hDEAD : 32'h0);
        tick();
        chk("stall_c3", a, FWD ? 32'hDEAD : 32'h0);
        ex_ready = 1'b1;
        tick();

        // Flush concurrent with a handshake drops the instruction
        issue(1, 1, 2, 32'h5, 32'h6, 0, 0, ALU_AND, 0, 12, 1, 0);
        flush = 1'b1; #1;
        chk("flush_ready", {31'd0, id_ready}, 1);
        tick();
        chk("flush_drop", {31'd0, ex_valid}, 0);
        flush = 1'b0;
        tick();
        idle(); ex_ready = 1'b0;
        tick();
        chk("hold_valid", {31'd0, ex_valid}, 1);
        flush = 1'b1;
        tick();
        chk("flush_hold", {31'd0, ex_valid}, 0);
        idle();

        // Immediate operand with rs2 forwarded to store_data
        issue(1, 1, 9, 32'h3, 0, 32'hFFFF_FFFC, 1, ALU_ADD, 0, 10, 1, 0);
        srcs(9, 1, 0, 32'h5, 0, 0, 0); #1;
        chk("imm_ready", {31'd0, id_ready}, 1);
        tick();
        id_valid = 1'b0; #1;
        chk("imm_b", b, 32'hFFFF_FFFC);
        chk("imm_store", store_data, FWD ? 32'h5 : 32'h0);
        chk("imm_a", a, 32'h3);
        idle(); tick();

        // RAW against MEM/WB only
        srcs(0, 0, 0, 0, 4, 1, 32'h44);
        issue(1, 4, 0, 32'h1, 0, 0, 0, ALU_XOR, 0, 11, 1, 0); #1;
        chk("raw_ready", {31'd0, id_ready}, {31'd0, FWD});
        tick();
        chk("raw_valid", {31'd0, ex_valid}, {31'd0, FWD});
        chk("raw_ready2", {31'd0, id_ready}, {31'd0, FWD});
        srcs(0, 0, 0, 0, 0, 0, 0); #1;
        chk("raw_clear", {31'd0, id_ready}, 1);
        tick();
        chk("raw_accept", {31'd0, ex_valid}, 1);
        chk("raw_a", a, 32'h1);
        chk("raw_alucont", {28'd0, alucont}, {28'd0, ALU_XOR});

        // Reset while stalled empties the stage
        idle(); ex_ready = 1'b0;
        tick();
        resetn = 1'b0;
        tick();
        chk("rst_stall", {31'd0, ex_valid}, 0);
        resetn = 1'b1; ex_ready = 1'b1;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
